// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers,
// plus MTHI/MTLO writes. Sits beside the EX-stage ALU and stalls the pipeline
// while a result is pending.
// Optional build macro: MULDIV_EARLY_OUT_EN -- a multiply finishes as soon as
// the remaining multiplier magnitude is zero. Division timing is unaffected.
module mips_muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             read_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [WIDTH:0]         rem_q, rem_d;
  logic [WIDTH-1:0]       quo_q, quo_d, dvsr_q, dvsr_d;
  logic                   neg_q, neg_d, rneg_q, rneg_d;
  logic                   dz_q, dz_d, dzf_q, dzf_d;
  logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;

  // one-step datapath results and sign-corrected final values
  logic [2*WIDTH-1:0]     acc_s, mcand_s, prod_fix;
  logic [WIDTH-1:0]       mplier_s, quo_s, q_fix, r_fix;
  logic [WIDTH:0]         rem_s;
  logic                   mul_last;
  // operand decode at launch
  logic                   sa, sb;
  logic [WIDTH-1:0]       ma, mb;

  assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
  assign stall       = busy & (start | read_req);
  assign done        = (state_q == S_FIN);
  assign div_by_zero = dzf_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  // operand signs (signed ops have op[0] clear) and magnitudes
  always_comb begin
    sa = ~op[0] & a[WIDTH-1];
    sb = ~op[0] & b[WIDTH-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
  end

  // one iteration: BITS_PER_CYCLE shift-add bits and restoring-divide bits
  always_comb begin
    acc_s = acc_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++)
      if (mplier_q[k]) acc_s = acc_s + (mcand_q << k);
    mcand_s  = mcand_q << BITS_PER_CYCLE;
    mplier_s = mplier_q >> BITS_PER_CYCLE;
    rem_s = rem_q;
    quo_s = quo_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      rem_s = {rem_s[WIDTH-1:0], quo_s[WIDTH-1]};
      quo_s = {quo_s[WIDTH-2:0], 1'b0};
      if (rem_s >= {1'b0, dvsr_q}) begin
        rem_s    = rem_s - {1'b0, dvsr_q};
        quo_s[0] = 1'b1;
      end
    end
    prod_fix = neg_q  ? -acc_s : acc_s;
    q_fix    = neg_q  ? -quo_s : quo_s;
    r_fix    = rneg_q ? -rem_s[WIDTH-1:0] : rem_s[WIDTH-1:0];
`ifdef MULDIV_EARLY_OUT_EN
    mul_last = (cnt_q == '0) || (mplier_s == '0);
`else
    mul_last = (cnt_q == '0);
`endif
  end

  // next-state, datapath load and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    dzf_d    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      // FIN also accepts a launch: stall is low there, so the op EX
      // re-presents after a stall must not be dropped.
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, ma};
              mplier_d = mb;
              neg_d    = sa ^ sb;
              cnt_d    = CNT_INIT;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              // divide-by-zero spends one busy cycle in DIV carrying the raw
              // dividend, then lands in FIN with hi = a, lo = all ones
              dz_d    = (b == '0);
              rem_d   = '0;
              quo_d   = (b == '0) ? a : ma;
              dvsr_d  = mb;
              neg_d   = sa ^ sb;
              rneg_d  = sa;
              cnt_d   = (b == '0) ? '0 : CNT_INIT;
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d    = acc_s;
        mcand_d  = mcand_s;
        mplier_d = mplier_s;
        cnt_d    = cnt_q - 1'b1;
        if (mul_last) begin
          {hi_d, lo_d} = prod_fix;
          state_d      = S_FIN;
        end
      end
      S_DIV: begin
        rem_d = rem_s;
        quo_d = quo_s;
        cnt_d = cnt_q - 1'b1;
        if (dz_q) begin
          hi_d    = quo_q;
          lo_d    = '1;
          dzf_d   = 1'b1;
          state_d = S_FIN;
        end else if (cnt_q == '0) begin
          hi_d    = r_fix;
          lo_d    = q_fix;
          state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers; reset aborts any op in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      dzf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      dzf_q    <= dzf_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (WIDTH=32, BITS_PER_CYCLE=1).
// Expected results come from plain integer arithmetic on the operands.
module tb_mips_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, read_req;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .read_req(read_req), .busy(busy), .stall(stall), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  // reference result {hi, lo} from integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    case (o)
      3'd0: begin sp = longint'($signed(x)) * longint'($signed(y)); return sp; end
      3'd1: begin up = {32'd0, x} * {32'd0, y}; return up; end
      3'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        sx = $signed(x); sy = $signed(y);
        return {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // expected cycle in which done appears
  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] y);
    logic [31:0] m;
    int          nb;
    if (o[1]) return (y == 0) ? 2 : 33;
`ifdef MULDIV_EARLY_OUT_EN
    m  = (o == 3'd0 && y[31]) ? -y : y;
    nb = 0;
    while (m != 0) begin m = m >> 1; nb++; end
    if (nb < 1) nb = 1;
    return nb + 1;
`else
    m = y; nb = 0;
    return 33 + nb + int'(m[0] & 1'b0);
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  // launch one op (start sampled at edge 0) and wait, bounded, for done
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_cnt, output bit dz_seen);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    lat = 0; busy_cnt = 0; dz_seen = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin lat = c; dz_seen = div_by_zero; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; read_req = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({hi, lo} !== 64'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, want all zero", hi, lo, busy, done, div_by_zero);
    end
    rst = 1'b1;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat, bc; bit dz;
    logic [63:0] e;
    e = model(o, x, y);
    run_op(o, x, y, lat, bc, dz);
    exp_hi = e[63:32]; exp_lo = e[31:0];
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      failures++;
      $display("FAIL %s result: op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", name, o, x, y, hi, lo, exp_hi, exp_lo);
    end
    checks++;
    if (lat !== exp_latency(o, y)) begin
      failures++;
      $display("FAIL %s latency: op=%0d a=%h b=%h got %0d want %0d", name, o, x, y, lat, exp_latency(o, y));
    end
    checks++;
    if (dz !== (o[1] && y == 0)) begin
      failures++;
      $display("FAIL %s div_by_zero: got %b want %b", name, dz, (o[1] && y == 0));
    end
  endtask

  task automatic test_mul();
    check_op("mult_neg2x3",  3'd0, 32'hFFFFFFFE, 32'd3);
    check_op("multu_neg2x3", 3'd1, 32'hFFFFFFFE, 32'd3);
    check_op("multu_5x3",    3'd1, 32'd5, 32'd3);
  endtask

  task automatic test_div();
    check_op("div_neg7_2",   3'd2, 32'hFFFFFFF9, 32'd2);
    check_op("divu_7_2",     3'd3, 32'd7, 32'd2);
    check_op("div_min_neg1", 3'd2, 32'h80000000, 32'hFFFFFFFF);
  endtask

  task automatic test_div_zero();
    int lat, bc; bit dz;
    run_op(3'd3, 32'h12345678, 32'd0, lat, bc, dz);
    exp_hi = 32'h12345678; exp_lo = 32'hFFFFFFFF;
    checks++;
    if (bc !== 1) begin failures++; $display("FAIL divzero_busy: got %0d cycles want 1", bc); end
    checks++;
    if (dz !== 1'b1 || lat == 0) begin failures++; $display("FAIL divzero_pulse: dz=%b lat=%0d want dz=1 with done", dz, lat); end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      failures++; $display("FAIL divzero_result: hi=%h lo=%h want %h %h", hi, lo, exp_hi, exp_lo);
    end
    @(negedge clk);
    checks++;
    if (div_by_zero !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL divzero_one_cycle: dz=%b done=%b want 0 0", div_by_zero, done);
    end
  endtask

  task automatic test_mtxx();
    bit saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    saw_done |= done;
    checks++;
    if (hi !== 32'hA5A5A5A5 || lo !== exp_lo || busy !== 1'b0) begin
      failures++; $display("FAIL mthi: hi=%h lo=%h busy=%b want hi=a5a5a5a5 lo=%h busy=0", hi, lo, busy, exp_lo);
    end
    op = 3'd5; a = 32'h5A5A5A5A;
    @(posedge clk);
    @(negedge clk);
    saw_done |= done;
    start = 1'b0;
    exp_hi = 32'hA5A5A5A5; exp_lo = 32'h5A5A5A5A;
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      failures++; $display("FAIL mtlo: hi=%h lo=%h want %h %h", hi, lo, exp_hi, exp_lo);
    end
    // an undefined op code changes nothing
    start = 1'b1; op = 3'd6; a = 32'h11111111; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin @(negedge clk); saw_done |= done | busy; end
    checks++;
    if (saw_done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      failures++; $display("FAIL mtxx_no_done: done_or_busy_seen=%b hi=%h lo=%h want 0 %h %h", saw_done, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_stall();
    logic [63:0] e;
    bit          exp_st;
    e = model(3'd0, 32'h00012345, 32'hFFFF0003);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h00012345; b = 32'hFFFF0003;
    @(posedge clk);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      start    = (c == 10);
      op       = 3'd5;
      a        = 32'hDEADBEEF;
      read_req = (c >= 5);
      #1;
      exp_st = (c >= 5 && c <= 32) || (c == 10);
      checks++;
      if (stall !== exp_st) begin
        failures++; $display("FAIL stall_cycle%0d: got %b want %b", c, stall, exp_st);
      end
      if (c == 33) begin
        checks++;
        if (done !== 1'b1 || hi !== e[63:32] || lo !== e[31:0]) begin
          failures++; $display("FAIL stall_done: done=%b hi=%h lo=%h want 1 %h %h", done, hi, lo, e[63:32], e[31:0]);
        end
      end
    end
    read_req = 1'b0; start = 1'b0;
    exp_hi = e[63:32]; exp_lo = e[31:0];
    repeat (2) @(negedge clk);
    checks++;
    if (lo !== exp_lo || busy !== 1'b0) begin
      failures++; $display("FAIL ignored_start: lo=%h busy=%b want %h 0", lo, busy, exp_lo);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h00000007; b = 32'h00000009;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid: hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin @(negedge clk); saw_done |= done; end
    exp_hi = '0; exp_lo = '0;
    checks++;
    if (saw_done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL reset_mid_after: done_seen=%b hi=%h lo=%h want 0 0 0", saw_done, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      x = pick();
      y = pick();
      check_op("random", o, x, y);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_mtxx();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
